// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit R-type ALU: decodes instruction words, drives the
// ALU operand registers from a 32x32 register file and writes the result back.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        load_en,
  input  logic [4:0]  load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] Source1,
  output logic [31:0] Source2,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_zero,
  output logic        wb_carry,
  output logic        err
);

  localparam logic [5:0] FN_ADD = 6'd27;
  localparam logic [5:0] FN_AND = 6'd32;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_ERR} state_t;

  state_t      r_state;
  logic [4:0]  r_rs, r_rt, r_rd, r_sh;
  logic [5:0]  r_fn;
  logic [31:0] r_src1, r_src2;
  logic [5:0]  r_funct;
  logic [4:0]  r_shamt;
  logic        r_wb_valid, r_wb_zero, r_wb_carry, r_err;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic [31:0] r_rf [32];

  logic        w_hs, w_legal, w_wb_we;
  logic [31:0] w_rs_val, w_rt_val;

  assign instr_ready = (r_state == S_IDLE) && !rst;
  assign w_hs        = instr_valid && instr_ready;
  assign w_legal     = (instr[31:26] == 6'd0) && (instr[5:0] >= FN_ADD) && (instr[5:0] <= FN_AND);
  assign w_wb_we     = (r_state == S_CAPTURE);
  assign w_rs_val    = (r_rs == 5'd0) ? 32'd0 : r_rf[r_rs];
  assign w_rt_val    = (r_rt == 5'd0) ? 32'd0 : r_rf[r_rt];

  assign Source1  = r_src1;
  assign Source2  = r_src2;
  assign funct    = r_funct;
  assign shamt    = r_shamt;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign wb_zero  = r_wb_zero;
  assign wb_carry = r_wb_carry;
  assign err      = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_sh       <= '0;
      r_fn       <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_funct    <= '0;
      r_shamt    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_zero  <= 1'b0;
      r_wb_carry <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_rs    <= instr[25:21];
            r_rt    <= instr[20:16];
            r_rd    <= instr[15:11];
            r_sh    <= instr[10:6];
            r_fn    <= instr[5:0];
            r_state <= w_legal ? S_DRIVE : S_ERR;
          end
        end
        // ALU inputs only ever change here, so an illegal funct never reaches the ALU.
        S_DRIVE: begin
          r_src1  <= w_rs_val;
          r_src2  <= w_rt_val;
          r_funct <= r_fn;
          r_shamt <= r_sh;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_wb_data  <= alu_result;
          r_wb_zero  <= alu_zero;
          r_wb_carry <= (r_fn == FN_ADD) && alu_carry;
          r_state    <= S_IDLE;
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback takes priority over a same-cycle preload to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_wb_we && (r_rd == i[4:0]))
          r_rf[i] <= alu_result;
        else if (load_en && (load_addr == i[4:0]))
          r_rf[i] <= load_data;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing controller that drives the 32-bit R-type ALU from the initiator side. It accepts R-type instruction words over a valid/ready handshake and decodes them. It reads operands from an internal 32×32 register file, presents `Source1`/`Source2`/`funct`/`shamt` to the ALU, captures `result`/`zero`/`carry` one cycle later, and writes the result back to `rd`. It sits between the instruction source and the combinational ALU and is the only block that drives the ALU's inputs.

## Interface
- No parameters; data width 32, register count 32, both fixed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: instruction word offered.
- `instr` in 32: `[31:26]` opcode (must be 0), `[25:21]` rs, `[20:16]` rt, `[15:11]` rd, `[10:6]` shamt, `[5:0]` funct.
- `instr_ready` out 1: controller can accept an instruction.
- `load_en` in 1: host register preload strobe.
- `load_addr` in 5: preload address.
- `load_data` in 32: preload data.
- `Source1` out 32: ALU operand 1, registered.
- `Source2` out 32: ALU operand 2, registered.
- `funct` out 6: ALU function code, registered.
- `shamt` out 5: ALU shift amount, registered.
- `alu_result` in 32: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `alu_carry` in 1: ALU carry flag.
- `wb_valid` out 1: one-cycle pulse, writeback completed.
- `wb_rd` out 5: destination of the completed op.
- `wb_data` out 32: result written.
- `wb_zero` out 1: zero flag of the completed op.
- `wb_carry` out 1: carry of the completed op; 0 unless funct = ADD.
- `err` out 1: one-cycle pulse, illegal instruction rejected.

## Operation
- Legal funct codes: 27 ADD, 28 SUB, 29 SRL (by shamt), 30 SLL (by shamt), 31 XOR, 32 AND.
- An instruction is illegal if the opcode is non-zero or funct is outside 27..32.
- Register file:
  - r0 reads as 0 and is never written.
  - Writeback to rd=0 still pulses `wb_valid` with the ALU data, but r0 stays 0.
- States:
  - **IDLE**: `instr_ready`=1. On handshake, go to DRIVE if legal, ERR if illegal.
  - **DRIVE**: `Source1`←R[rs], `Source2`←R[rt], `funct`, `shamt` registered onto the ALU inputs. Always go to CAPTURE.
  - **CAPTURE**: sample ALU outputs.
    - R[rd]←`alu_result`.
    - `wb_*` set, with `wb_carry`=`alu_carry` only if funct=27, else 0.
    - `wb_valid`=1. Go to IDLE.
  - **ERR**: `err`=1. ALU input registers unchanged, no register write. Go to IDLE.
- The ALU holds its last result for unknown funct codes. The controller therefore never drives an illegal funct: the ALU input registers change only in DRIVE.
- Preload port:
  - Writes R[`load_addr`] in any state; `load_addr`=0 is ignored.
  - If it targets the same address as a CAPTURE writeback in the same cycle, the writeback wins.
  - Preloads in the cycle before DRIVE are visible to that DRIVE.
- Reset, asynchronous, in any state:
  - State returns to IDLE and all register-file entries clear to 0.
  - `Source1`, `Source2`, `funct`, `shamt`, all `wb_*`, and `err` go to 0.
  - `instr_ready`=0 while `rst` is high.
  - An in-flight instruction is dropped with no writeback.

## Timing
- Handshake at edge T (`instr_valid`&&`instr_ready`):
  - T+1: ALU inputs valid (DRIVE), or `err` high (ERR).
  - T+2: `wb_valid`, `wb_data`, `wb_rd` valid, and R[rd] updated at the end of that cycle.
  - T+3: `instr_ready` high again.
- Throughput: one legal instruction per 3 cycles; one illegal instruction per 2 cycles.
- `instr_ready`=(state==IDLE)&&!rst. `instr` is sampled only at the handshake edge.
- Back-to-back dependency: an instruction accepted at T+3 that reads the previous rd sees the new value at its DRIVE.
- `wb_valid` and `err` are single-cycle pulses and never assert together.
- ALU input registers hold their values outside DRIVE, so `alu_result` stays stable into CAPTURE.

## Test plan
- Reset: assert `rst` mid-DRIVE → all outputs 0, `instr_ready`=0 during reset, no `wb_valid`; after release, R1 reads 0.
- ADD carry: preload R1=0xFFFFFFFF, R2=1; ADD rd=3 → `wb_data`=0, `wb_zero`=1, `wb_carry`=1 at T+2; then XOR R3,R3 → `wb_carry`=0.
- SUB wrap and dependency: R1=5, R2=7; SUB rd=4, then AND R4,R4 → rd=5 issued at T+3 gives `wb_data`=0xFFFFFFFE twice.
- Shifts: R1=0x80000000; SRL shamt=4 → 0x08000000; SLL shamt=1 → 0, `wb_zero`=1.
- Illegal: funct=33, and separately opcode=1 with funct=27 → `err` pulse at T+1, no `wb_valid`, `funct`/`Source*` unchanged, `instr_ready` high at T+2.
- r0 and preload collision:
  - ADD with rd=0 → `wb_valid`=1, R0 still reads 0.
  - Preload to rd in the same cycle as CAPTURE → R[rd] holds the ALU result.
